pipeline_hazard_unit: RTL and testbench
=======================================

// Module: pipeline_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the Kaiserlake 5-stage pipeline (S0 decode..S4 regwrt).
//  Selects forwarded operands per source register and generates update_s1 plus per-stage flush/hold.
//  Sequences load-use stalls, taken-branch squash bubbles and data-memory wait-states.
//  Keeps saturating stall/flush statistics.
//  Sits beside the pipeline assembly; drives its update_1in/rst_p and the S2 operand inputs.
// PARAMETERS
//  DATA_W      16  datapath width
//  REG_W       3   register-number width
//  NUM_SRC     3   source operands per instruction (Rm,Rn,Rd)
//  FWD_STAGES  2   forwarding taps ahead of writeback; tap 0 = youngest (S2 out)
//  NSTAGE      5   pipeline stages; flush/hold cover S1..S(NSTAGE-1)
//  LD_LAT      2   load-use stall cycles, >=1
//  BR_BUBBLES  2   extra squash cycles after a taken branch, >=0
//  CNT_W       16  statistics counter width
// PORTS
//  clk          in   1                   clock, rising edge
//  rst          in   1                   synchronous, active-high reset
//  src_num      in   NUM_SRC*REG_W       S1 source register numbers
//  src_used     in   NUM_SRC             per-source valid
//  rf_data      in   NUM_SRC*DATA_W      register-file read data
//  fwd_num      in   FWD_STAGES*REG_W    destination number per tap
//  fwd_write    in   FWD_STAGES          tap writes a register
//  fwd_data     in   FWD_STAGES*DATA_W   tap result
//  wb_num       in   REG_W               writeback register
//  wb_write     in   1                   writeback enable
//  wb_data      in   DATA_W              writeback data
//  ld_pending   in   1                   S2 holds a load
//  ld_num       in   REG_W               that load's destination
//  branch_taken in   1                   S3 resolved taken branch
//  mem_busy     in   1                   data memory not ready
//  op_data      out  NUM_SRC*DATA_W      forwarded operands to S2
//  update_s1    out  1                   S0->S1 advance
//  flush        out  NSTAGE-1            per-stage squash, bit i = S(i+1)
//  hold         out  NSTAGE-1            per-stage freeze
//  stall_cnt    out  CNT_W               cycles with update_s1=0, saturating
//  flush_cnt    out  CNT_W               taken-branch events, saturating
// BEHAVIOUR
//  Forwarding (comb): per source, first match of tap 0..FWD_STAGES-1 (write & num==src),
//   then wb, else rf_data. Unused sources pass rf_data.
//  FSM states: RUN, LDSTALL, MEMWAIT, BRFLUSH. Down-counter cnt, width clog2(max(LD_LAT,BR_BUBBLES)+1).
//  Priority per cycle: rst > mem_busy > branch_taken > load-use > none.
//  mem_busy (any state): hold=all 1, flush=0, update_s1=0.
//   Enter MEMWAIT; state and cnt frozen. Leave to the saved state the cycle after mem_busy=0.
//  branch_taken (not held): flush[1:0]=11, update_s1=1.
//   If BR_BUBBLES>0, go BRFLUSH with cnt=BR_BUBBLES; this overrides LDSTALL.
//   flush_cnt++.
//  BRFLUSH: flush[0]=1, update_s1=1, cnt--. Go RUN when cnt reaches 1 is consumed.
//  Load-use: in RUN, ld_pending & any used src matches ld_num.
//   update_s1=0, hold[0]=1, flush[1]=1 (bubble into S2).
//   If LD_LAT>1, go LDSTALL with cnt=LD_LAT-1.
//  LDSTALL: same outputs as load-use. Go RUN after cnt cycles.
//  RUN, no event: update_s1=1, flush=0, hold=0.
//  Counters: stall_cnt increments each non-reset cycle with update_s1=0. Both counters saturate at all-ones.
//  Reset, in any state mid-operation: next state RUN, cnt=0, both counters=0.
//   Outputs during rst=1: flush=all 1, hold=0, update_s1=0, op_data per forwarding.
//  No added latency on operands. Control outputs are comb from state+inputs.
// STRUCTURE
//  Package kl_pipe_pkg: hz_state_e enum, stage-index localparams (S_READREG..S_REGWRT).
//  Sub-module pipeline_fwd_mux: one operand's priority select.
//   Instantiate NUM_SRC copies via generate.
//  Top holds the FSM and counters.
// TESTING
//  1 Tap0 writes r3=0x1234, wb writes r3=0xBEEF, src0=r3 used -> op_data[0]=0x1234.
//    Drop tap0 -> 0xBEEF.
//  2 ld_pending, ld_num=2, src1=r2 used, LD_LAT=2 -> update_s1=0 for 2 cycles,
//    flush[1]=1 both cycles, stall_cnt=2.
//  3 branch_taken 1 cycle, BR_BUBBLES=2 -> flush=0011, then 0001 x2, then RUN; flush_cnt=1.
//  4 mem_busy 3 cycles during LDSTALL cnt=1 -> hold=1111 x3, then 1 more LDSTALL cycle, then RUN.
//  5 rst asserted in BRFLUSH -> next cycle RUN, counters 0, flush=1111 while rst high.
//  6 Force stall_cnt to 0xFFFF, then a stall cycle -> stays 0xFFFF.

Source files
------------

// File: rtl/kl_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kl_pipe_pkg
//  Description : Shared types and constants for the Kaiserlake 5-stage
//                pipeline hazard/forwarding control.
//  Revision    : 1.0  initial release
// ============================================================================
package kl_pipe_pkg;

    // Hazard sequencer states; MEMWAIT remembers the interrupted state separately
    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_LDSTALL = 2'd1,
        HZ_MEMWAIT = 2'd2,
        HZ_BRFLUSH = 2'd3
    } hz_state_e;

    // Pipeline stage indices (S0 decode .. S4 register write)
    localparam int S_DECODE  = 0;
    localparam int S_READREG = 1;
    localparam int S_EXEC    = 2;
    localparam int S_MEMACC  = 3;
    localparam int S_REGWRT  = 4;

    // Larger of two integers, used to size the shared down-counter
    function automatic int hz_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_fwd_mux
//  Description : Priority operand select for one source register: youngest
//                forwarding tap first, then writeback, else register file.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_fwd_mux #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 3,
    parameter int FWD_STAGES = 2
) (
    input  logic [REG_W-1:0]             i_src_num,
    input  logic                         i_src_used,
    input  logic [DATA_W-1:0]            i_rf_data,
    input  logic [FWD_STAGES*REG_W-1:0]  i_fwd_num,
    input  logic [FWD_STAGES-1:0]        i_fwd_write,
    input  logic [FWD_STAGES*DATA_W-1:0] i_fwd_data,
    input  logic [REG_W-1:0]             i_wb_num,
    input  logic                         i_wb_write,
    input  logic [DATA_W-1:0]            i_wb_data,
    output logic [DATA_W-1:0]            o_op_data
);

    logic [DATA_W-1:0] w_sel;

    // Oldest source applied first so younger matches overwrite it; tap 0 wins last
    always_comb begin
        w_sel = i_rf_data;
        if (i_src_used) begin
            if (i_wb_write && (i_wb_num == i_src_num))
                w_sel = i_wb_data;
            for (int t = FWD_STAGES - 1; t >= 0; t--) begin
                if (i_fwd_write[t] && (i_fwd_num[t*REG_W +: REG_W] == i_src_num))
                    w_sel = i_fwd_data[t*DATA_W +: DATA_W];
            end
        end
    end

    assign o_op_data = w_sel;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_unit
//  Description : Hazard/forwarding controller: operand forwarding, load-use
//                stalls, branch squash bubbles, memory wait-states and
//                saturating stall/flush statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_unit
    import kl_pipe_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 3,
    parameter int NUM_SRC    = 3,
    parameter int FWD_STAGES = 2,
    parameter int NSTAGE     = 5,
    parameter int LD_LAT     = 2,
    parameter int BR_BUBBLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*REG_W-1:0]     src_num,
    input  logic [NUM_SRC-1:0]           src_used,
    input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
    input  logic [FWD_STAGES*REG_W-1:0]  fwd_num,
    input  logic [FWD_STAGES-1:0]        fwd_write,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
    input  logic [REG_W-1:0]             wb_num,
    input  logic                         wb_write,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         ld_pending,
    input  logic [REG_W-1:0]             ld_num,
    input  logic                         branch_taken,
    input  logic                         mem_busy,
    output logic [NUM_SRC*DATA_W-1:0]    op_data,
    output logic                         update_s1,
    output logic [NSTAGE-2:0]            flush,
    output logic [NSTAGE-2:0]            hold,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    localparam int C_CNT_MAX = hz_max(LD_LAT, BR_BUBBLES);
    localparam int C_CW      = $clog2(C_CNT_MAX + 1);
    // flush/hold bit i controls stage S(i+1)
    localparam int C_FB_S1   = S_READREG - 1;
    localparam int C_FB_S2   = S_EXEC - 1;

    hz_state_e         r_state, r_saved;
    logic [C_CW-1:0]   r_cnt;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    hz_state_e         w_cur, w_nstate, w_nsaved;
    logic [C_CW-1:0]   w_ncnt;
    logic              w_update, w_br_evt, w_ld_hit;
    logic [NSTAGE-2:0] w_flush, w_hold;

    // One priority forwarding mux per source operand
    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_fwd
            pipeline_fwd_mux #(
                .DATA_W     (DATA_W),
                .REG_W      (REG_W),
                .FWD_STAGES (FWD_STAGES)
            ) u_mux (
                .i_src_num   (src_num[s*REG_W +: REG_W]),
                .i_src_used  (src_used[s]),
                .i_rf_data   (rf_data[s*DATA_W +: DATA_W]),
                .i_fwd_num   (fwd_num),
                .i_fwd_write (fwd_write),
                .i_fwd_data  (fwd_data),
                .i_wb_num    (wb_num),
                .i_wb_write  (wb_write),
                .i_wb_data   (wb_data),
                .o_op_data   (op_data[s*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Load-use hazard: the S2 load targets any register S1 actually reads
    always_comb begin
        w_ld_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_used[s] && (src_num[s*REG_W +: REG_W] == ld_num))
                w_ld_hit = 1'b1;
        end
        w_ld_hit = w_ld_hit & ld_pending;
    end

    // Once memory is ready, MEMWAIT behaves exactly like the interrupted state
    assign w_cur = (r_state == HZ_MEMWAIT) ? r_saved : r_state;

    // Control outputs and next-state, priority rst > mem_busy > branch > load-use
    always_comb begin
        w_update = 1'b1;
        w_flush  = '0;
        w_hold   = '0;
        w_nstate = w_cur;
        w_nsaved = r_saved;
        w_ncnt   = r_cnt;
        w_br_evt = 1'b0;
        if (rst) begin
            w_update = 1'b0;
            w_flush  = '1;
        end else if (mem_busy) begin
            w_update = 1'b0;
            w_hold   = '1;
            w_nstate = HZ_MEMWAIT;
            w_nsaved = w_cur;
        end else if (branch_taken) begin
            w_flush[C_FB_S1] = 1'b1;
            w_flush[C_FB_S2] = 1'b1;
            w_br_evt         = 1'b1;
            if (BR_BUBBLES > 0) begin
                w_nstate = HZ_BRFLUSH;
                w_ncnt   = C_CW'(BR_BUBBLES);
            end else begin
                w_nstate = HZ_RUN;
                w_ncnt   = '0;
            end
        end else begin
            case (w_cur)
                HZ_BRFLUSH: begin
                    w_flush[C_FB_S1] = 1'b1;
                    if (r_cnt <= C_CW'(1)) begin
                        w_nstate = HZ_RUN;
                        w_ncnt   = '0;
                    end else begin
                        w_ncnt   = r_cnt - C_CW'(1);
                    end
                end
                HZ_LDSTALL: begin
                    w_update         = 1'b0;
                    w_hold[C_FB_S1]  = 1'b1;
                    w_flush[C_FB_S2] = 1'b1;
                    if (r_cnt <= C_CW'(1)) begin
                        w_nstate = HZ_RUN;
                        w_ncnt   = '0;
                    end else begin
                        w_ncnt   = r_cnt - C_CW'(1);
                    end
                end
                default: begin
                    w_nstate = HZ_RUN;
                    if (w_ld_hit) begin
                        w_update         = 1'b0;
                        w_hold[C_FB_S1]  = 1'b1;
                        w_flush[C_FB_S2] = 1'b1;
                        if (LD_LAT > 1) begin
                            w_nstate = HZ_LDSTALL;
                            w_ncnt   = C_CW'(LD_LAT - 1);
                        end
                    end
                end
            endcase
        end
    end

    // State, down-counter and saturating statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HZ_RUN;
            r_saved     <= HZ_RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_nstate;
            r_saved <= w_nsaved;
            r_cnt   <= w_ncnt;
            if (!w_update && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_br_evt && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign update_s1 = w_update;
    assign flush     = w_flush;
    assign hold      = w_hold;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_unit
//  Description : Directed self-checking bench for pipeline_hazard_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  src_num;
    logic [2:0]  src_used;
    logic [47:0] rf_data;
    logic [5:0]  fwd_num;
    logic [1:0]  fwd_write;
    logic [31:0] fwd_data;
    logic [2:0]  wb_num;
    logic        wb_write;
    logic [15:0] wb_data;
    logic        ld_pending;
    logic [2:0]  ld_num;
    logic        branch_taken;
    logic        mem_busy;
    logic [47:0] op_data;
    logic        update_s1;
    logic [3:0]  flush;
    logic [3:0]  hold;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .src_num      (src_num),
        .src_used     (src_used),
        .rf_data      (rf_data),
        .fwd_num      (fwd_num),
        .fwd_write    (fwd_write),
        .fwd_data     (fwd_data),
        .wb_num       (wb_num),
        .wb_write     (wb_write),
        .wb_data      (wb_data),
        .ld_pending   (ld_pending),
        .ld_num       (ld_num),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .op_data      (op_data),
        .update_s1    (update_s1),
        .flush        (flush),
        .hold         (hold),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rf_data = 48'hAAAA_5555_0F0F;
        src_used = 3'b111;
        @(negedge clk);
        n_checks++; if (flush !== 4'hF) begin n_errors++; $display("FAIL reset_flush got %h want %h", flush, 4'hF); end
        n_checks++; if (hold !== 4'h0) begin n_errors++; $display("FAIL reset_hold got %h want %h", hold, 4'h0); end
        n_checks++; if (update_s1 !== 1'b0) begin n_errors++; $display("FAIL reset_update got %b want 0", update_s1); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_stall_cnt got %h want 0", stall_cnt); end
        n_checks++; if (flush_cnt !== 16'h0) begin n_errors++; $display("FAIL reset_flush_cnt got %h want 0", flush_cnt); end
        n_checks++; if (op_data !== 48'hAAAA_5555_0F0F) begin n_errors++; $display("FAIL reset_op_data got %h want %h", op_data, 48'hAAAA_5555_0F0F); end
        @(posedge clk); #1;
        rst = 1'b0;
        src_used = 3'b000;
    endtask

    task automatic test_forwarding();
        // src0=r3, src1=r3, src2=r5
        src_num   = {3'd5, 3'd3, 3'd3};
        src_used  = 3'b101;
        rf_data   = {16'h2222, 16'h1111, 16'h0000};
        fwd_num   = {3'd3, 3'd3};
        fwd_write = 2'b01;
        fwd_data  = {16'h5555, 16'h1234};
        wb_num    = 3'd3;
        wb_write  = 1'b1;
        wb_data   = 16'hBEEF;
        @(negedge clk);
        n_checks++; if (op_data[15:0] !== 16'h1234) begin n_errors++; $display("FAIL fwd_tap0 got %h want %h", op_data[15:0], 16'h1234); end
        n_checks++; if (op_data[31:16] !== 16'h1111) begin n_errors++; $display("FAIL fwd_unused got %h want %h", op_data[31:16], 16'h1111); end
        n_checks++; if (op_data[47:32] !== 16'h2222) begin n_errors++; $display("FAIL fwd_nomatch got %h want %h", op_data[47:32], 16'h2222); end
        n_checks++; if (update_s1 !== 1'b1 || flush !== 4'h0 || hold !== 4'h0) begin n_errors++; $display("FAIL run_idle got u=%b f=%h h=%h want u=1 f=0 h=0", update_s1, flush, hold); end
        fwd_write = 2'b00;
        #1;
        n_checks++; if (op_data[15:0] !== 16'hBEEF) begin n_errors++; $display("FAIL fwd_wb got %h want %h", op_data[15:0], 16'hBEEF); end
        fwd_write = 2'b10;
        #1;
        n_checks++; if (op_data[15:0] !== 16'h5555) begin n_errors++; $display("FAIL fwd_tap1 got %h want %h", op_data[15:0], 16'h5555); end
        fwd_write = 2'b11;
        #1;
        n_checks++; if (op_data[15:0] !== 16'h1234) begin n_errors++; $display("FAIL fwd_tap0_over_tap1 got %h want %h", op_data[15:0], 16'h1234); end
        wb_write = 1'b0;
        fwd_write = 2'b00;
        #1;
        n_checks++; if (op_data[15:0] !== 16'h0000) begin n_errors++; $display("FAIL fwd_rf got %h want 0", op_data[15:0]); end
        next_cycle();
    endtask

    task automatic test_load_use();
        src_num    = {3'd7, 3'd2, 3'd6};
        src_used   = 3'b001;
        ld_pending = 1'b1;
        ld_num     = 3'd2;
        @(negedge clk);
        n_checks++; if (update_s1 !== 1'b1) begin n_errors++; $display("FAIL ld_unused_src got %b want 1", update_s1); end
        src_used = 3'b010;
        #1;
        n_checks++; if (update_s1 !== 1'b0 || flush !== 4'b0010 || hold !== 4'b0001) begin n_errors++; $display("FAIL ld_cycle1 got u=%b f=%h h=%h want u=0 f=2 h=1", update_s1, flush, hold); end
        next_cycle();
        ld_pending = 1'b0;
        @(negedge clk);
        n_checks++; if (update_s1 !== 1'b0 || flush !== 4'b0010 || hold !== 4'b0001) begin n_errors++; $display("FAIL ld_cycle2 got u=%b f=%h h=%h want u=0 f=2 h=1", update_s1, flush, hold); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (update_s1 !== 1'b1 || flush !== 4'h0) begin n_errors++; $display("FAIL ld_done got u=%b f=%h want u=1 f=0", update_s1, flush); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_errors++; $display("FAIL ld_stall_cnt got %0d want 2", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        @(negedge clk);
        n_checks++; if (flush !== 4'b0011 || update_s1 !== 1'b1) begin n_errors++; $display("FAIL br_taken got f=%h u=%b want f=3 u=1", flush, update_s1); end
        next_cycle();
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (flush !== 4'b0001 || update_s1 !== 1'b1) begin n_errors++; $display("FAIL br_bubble%0d got f=%h u=%b want f=1 u=1", i, flush, update_s1); end
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (flush !== 4'h0) begin n_errors++; $display("FAIL br_done got f=%h want 0", flush); end
        n_checks++; if (flush_cnt !== 16'd1) begin n_errors++; $display("FAIL br_flush_cnt got %0d want 1", flush_cnt); end
        n_checks++; if (stall_cnt !== 16'd2) begin n_errors++; $display("FAIL br_stall_cnt got %0d want 2", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_memwait();
        // load-use puts the sequencer in LDSTALL with one cycle left
        ld_pending = 1'b1;
        next_cycle();
        ld_pending = 1'b0;
        mem_busy   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 1);
            @(negedge clk);
            n_checks++; if (hold !== 4'hF || flush !== 4'h0 || update_s1 !== 1'b0) begin n_errors++; $display("FAIL mem_busy%0d got h=%h f=%h u=%b want h=F f=0 u=0", i, hold, flush, update_s1); end
            next_cycle();
        end
        branch_taken = 1'b0;
        mem_busy     = 1'b0;
        @(negedge clk);
        n_checks++; if (update_s1 !== 1'b0 || flush !== 4'b0010 || hold !== 4'b0001) begin n_errors++; $display("FAIL mem_resume_ldstall got u=%b f=%h h=%h want u=0 f=2 h=1", update_s1, flush, hold); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (update_s1 !== 1'b1 || hold !== 4'h0) begin n_errors++; $display("FAIL mem_run got u=%b h=%h want u=1 h=0", update_s1, hold); end
        n_checks++; if (stall_cnt !== 16'd7) begin n_errors++; $display("FAIL mem_stall_cnt got %0d want 7", stall_cnt); end
        n_checks++; if (flush_cnt !== 16'd1) begin n_errors++; $display("FAIL mem_flush_cnt got %0d want 1", flush_cnt); end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        branch_taken = 1'b1;
        next_cycle();
        branch_taken = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (flush !== 4'hF || update_s1 !== 1'b0 || hold !== 4'h0) begin n_errors++; $display("FAIL rst_midop got f=%h u=%b h=%h want f=F u=0 h=0", flush, update_s1, hold); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (flush !== 4'h0 || update_s1 !== 1'b1) begin n_errors++; $display("FAIL rst_to_run got f=%h u=%b want f=0 u=1", flush, update_s1); end
        n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_errors++; $display("FAIL rst_counters got s=%0d f=%0d want 0 0", stall_cnt, flush_cnt); end
        next_cycle();
    endtask

    task automatic test_saturation();
        mem_busy = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL sat_reach got %h want FFFF", stall_cnt); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (stall_cnt !== 16'hFFFF) begin n_errors++; $display("FAIL sat_hold got %h want FFFF", stall_cnt); end
        next_cycle();
        mem_busy = 1'b0;
        @(negedge clk);
        n_checks++; if (update_s1 !== 1'b1 || hold !== 4'h0) begin n_errors++; $display("FAIL sat_run got u=%b h=%h want u=1 h=0", update_s1, hold); end
        next_cycle();
    endtask

    initial begin
        rst          = 1'b1;
        src_num      = '0;
        src_used     = '0;
        rf_data      = '0;
        fwd_num      = '0;
        fwd_write    = '0;
        fwd_data     = '0;
        wb_num       = '0;
        wb_write     = 1'b0;
        wb_data      = '0;
        ld_pending   = 1'b0;
        ld_num       = '0;
        branch_taken = 1'b0;
        mem_busy     = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_memwait();
        test_reset_midop();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
